// File: rtl/dmem_pkg.sv
// Shared types and funct3 encodings for the data-memory responder.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} dmem_state_t;

   // addr is held at full 32 bits so the struct is independent of DM_ADDRESS
   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  funct3;
   } dmem_req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for sub-word loads/stores, plus funct3/alignment legality.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  addr,
   input  logic [2:0]  funct3,
   input  logic        we,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wword,
   output logic [31:0] rdata,
   output logic        err
);

   logic [31:0] shifted;

   assign shifted = rword >> {addr, 3'b000};

   always_comb begin
      err   = 1'b0;
      be    = 4'b0000;
      wword = wdata;
      rdata = '0;
      case (funct3)
         F3_B: begin
            be    = 4'b0001 << addr;
            wword = {4{wdata[7:0]}};
            rdata = {{24{shifted[7]}}, shifted[7:0]};
         end
         F3_H: begin
            err   = addr[0];
            be    = addr[1] ? 4'b1100 : 4'b0011;
            wword = {2{wdata[15:0]}};
            rdata = {{16{shifted[15]}}, shifted[15:0]};
         end
         F3_W: begin
            err   = (addr != 2'b00);
            be    = 4'b1111;
            rdata = shifted;
         end
         F3_BU: begin
            err   = we;
            rdata = {24'b0, shifted[7:0]};
         end
         F3_HU: begin
            err   = we | addr[0];
            rdata = {16'b0, shifted[15:0]};
         end
         default: err = 1'b1;
      endcase
      // errors never touch memory and always return zero data
      if (err || !we) be = 4'b0000;
      if (err || we)  rdata = '0;
   end

endmodule

// File: rtl/dmem_responder.sv
// Byte-addressed little-endian data memory behind a valid/ready request/response
// handshake, with a configurable number of wait states before each response.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DM_ADDRESS  = 9,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [DM_ADDRESS-1:0] req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [2:0]            req_funct3,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_err
);

   localparam int DEPTH = 2 ** (DM_ADDRESS - 2);
   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   dmem_state_t           state, state_next;
   logic [CNT_W-1:0]      cnt;
   dmem_req_t             req_in, req_q, cur;
   logic                  enter_resp;
   logic [DM_ADDRESS-3:0] idx;
   logic [31:0]           rword, wword, ld_data;
   logic [3:0]            be;
   logic                  err;
   logic                  unused_addr_bits;

   logic [31:0] mem [DEPTH];

   assign req_ready = (state == IDLE) && !reset;
   assign rsp_valid = (state == RESP);

   assign req_in = '{we: req_we, addr: 32'(req_addr), wdata: req_wdata, funct3: req_funct3};

   // With zero wait states the access completes on the accept edge, before
   // req_q is loaded, so steer from the live request while idle.
   assign cur   = (state == IDLE) ? req_in : req_q;
   assign idx   = cur.addr[DM_ADDRESS-1:2];
   assign rword = mem[idx];
   assign unused_addr_bits = &{1'b0, cur.addr};

   dmem_lane_align u_align (
      .addr   (cur.addr[1:0]),
      .funct3 (cur.funct3),
      .we     (cur.we),
      .wdata  (cur.wdata),
      .rword  (rword),
      .be     (be),
      .wword  (wword),
      .rdata  (ld_data),
      .err    (err)
   );

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (req_valid) state_next = (WAIT_CYCLES > 0) ? BUSY : RESP;
         BUSY:    if (cnt == '0) state_next = RESP;
         RESP:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      enter_resp = (state_next == RESP) && (state != RESP);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state <= state_next;
         if (state == IDLE && req_valid)
            cnt <= CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
         else if (state == BUSY && cnt != '0)
            cnt <= cnt - 1'b1;
         if (enter_resp) begin
            rsp_rdata <= ld_data;
            rsp_err   <= err;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state == IDLE && req_valid && !reset)
         req_q <= req_in;
   end

   // Stores commit on entry to RESP; a reset while still BUSY drops them.
   always_ff @(posedge clk) begin
      if (!reset && enter_resp) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Table-driven scoreboard bench for dmem_responder (WAIT_CYCLES=2 and 0 instances).
module tb_dmem_responder;
   import dmem_pkg::*;

   localparam int WAITC = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
   logic [8:0]  req_addr;
   logic [31:0] req_wdata, rsp_rdata;
   logic [2:0]  req_funct3;

   logic        req_valid_z, req_ready_z, req_we_z, rsp_valid_z, rsp_ready_z, rsp_err_z;
   logic [8:0]  req_addr_z;
   logic [31:0] req_wdata_z, rsp_rdata_z;
   logic [2:0]  req_funct3_z;

   dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(WAITC)) u_dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_CYCLES(0)) u_dut_z (
      .clk(clk), .reset(reset), .req_valid(req_valid_z), .req_ready(req_ready_z),
      .req_we(req_we_z), .req_addr(req_addr_z), .req_wdata(req_wdata_z), .req_funct3(req_funct3_z),
      .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z), .rsp_rdata(rsp_rdata_z), .rsp_err(rsp_err_z)
   );

   typedef struct {
      logic        we;
      logic [8:0]  addr;
      logic [31:0] wdata;
      logic [2:0]  f3;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   vec_t vecs[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic we, input logic [8:0] a, input logic [31:0] d,
                               input logic [2:0] f, input logic [31:0] r, input logic e);
      vec_t v;
      v.we = we; v.addr = a; v.wdata = d; v.f3 = f; v.exp_rdata = r; v.exp_err = e;
      return v;
   endfunction

   // Drive a request until accepted, record its expected response, then scramble the bus.
   task automatic accept(input vec_t v);
      int   guard = 0;
      exp_t e;
      e.rdata = v.exp_rdata;
      e.err   = v.exp_err;
      exp_q.push_back(e);
      @(negedge clk);
      req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_funct3 = v.f3;
      while (!req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      chk("accept", {31'b0, req_ready}, 32'd1);
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_we     = 1'($urandom);
      req_addr   = 9'($urandom);
      req_wdata  = $urandom;
      req_funct3 = 3'($urandom);
   endtask

   task automatic finish_txn(input string tag, input int hold);
      int          lat = 1;
      exp_t        e;
      logic [31:0] d0;
      logic        e0;
      @(negedge clk);
      while (!rsp_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, ".lat"}, 32'(lat), 32'(WAITC + 1));
      e = exp_q.pop_front();
      chk({tag, ".rdata"}, rsp_rdata, e.rdata);
      chk({tag, ".err"}, {31'b0, rsp_err}, {31'b0, e.err});
      d0 = rsp_rdata;
      e0 = rsp_err;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({tag, ".hold_valid"}, {31'b0, rsp_valid}, 32'd1);
         chk({tag, ".hold_rdata"}, rsp_rdata, d0);
         chk({tag, ".hold_err"}, {31'b0, rsp_err}, {31'b0, e0});
         chk({tag, ".hold_ready"}, {31'b0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      chk({tag, ".idle"}, {30'b0, rsp_valid, req_ready}, 32'b01);
   endtask

   task automatic z_txn(input string tag, input vec_t v);
      @(negedge clk);
      req_valid_z = 1'b1; req_we_z = v.we; req_addr_z = v.addr; req_wdata_z = v.wdata; req_funct3_z = v.f3;
      chk({tag, ".ready"}, {31'b0, req_ready_z}, 32'd1);
      @(posedge clk);
      #1 req_valid_z = 1'b0;
      @(negedge clk);
      chk({tag, ".lat"}, {31'b0, rsp_valid_z}, 32'd1);
      chk({tag, ".rdata"}, rsp_rdata_z, v.exp_rdata);
      chk({tag, ".err"}, {31'b0, rsp_err_z}, {31'b0, v.exp_err});
      rsp_ready_z = 1'b1;
      @(posedge clk);
      #1 rsp_ready_z = 1'b0;
      @(negedge clk);
      chk({tag, ".idle"}, {30'b0, rsp_valid_z, req_ready_z}, 32'b01);
   endtask

   initial begin
      int seen;
      reset = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = '0; rsp_ready = 1'b0;
      req_valid_z = 1'b0; req_we_z = 1'b0; req_addr_z = '0; req_wdata_z = '0; req_funct3_z = '0; rsp_ready_z = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst.outputs", {req_ready, rsp_valid, rsp_err, 29'b0}, 32'b0);
      chk("rst.rdata", rsp_rdata, 32'b0);
      chk("rst.z_outputs", {req_ready_z, rsp_valid_z, rsp_err_z, 29'b0}, 32'b0);
      reset = 1'b0;
      @(negedge clk);
      chk("rst.ready_after", {31'b0, req_ready}, 32'd1);

      vecs.push_back(mk(1, 9'h010, 32'hDEADBEEF, F3_W,  32'h0,        0));
      vecs.push_back(mk(0, 9'h010, 32'h0,        F3_W,  32'hDEADBEEF, 0));
      vecs.push_back(mk(1, 9'h013, 32'h00000080, F3_B,  32'h0,        0));
      vecs.push_back(mk(0, 9'h013, 32'h0,        F3_B,  32'hFFFFFF80, 0));
      vecs.push_back(mk(0, 9'h013, 32'h0,        F3_BU, 32'h00000080, 0));
      vecs.push_back(mk(0, 9'h010, 32'h0,        F3_W,  32'h80ADBEEF, 0));
      vecs.push_back(mk(0, 9'h012, 32'h0,        F3_B,  32'hFFFFFFAD, 0));
      vecs.push_back(mk(0, 9'h012, 32'h0,        F3_HU, 32'h000080AD, 0));
      vecs.push_back(mk(0, 9'h010, 32'h0,        F3_H,  32'hFFFFBEEF, 0));
      vecs.push_back(mk(1, 9'h022, 32'h00008001, F3_H,  32'h0,        0));
      vecs.push_back(mk(0, 9'h022, 32'h0,        F3_H,  32'hFFFF8001, 0));
      vecs.push_back(mk(0, 9'h022, 32'h0,        F3_HU, 32'h00008001, 0));
      vecs.push_back(mk(0, 9'h021, 32'h0,        F3_H,  32'h0,        1));
      vecs.push_back(mk(1, 9'h030, 32'h11223344, F3_W,  32'h0,        0));
      vecs.push_back(mk(1, 9'h031, 32'hAAAA5555, F3_W,  32'h0,        1));
      vecs.push_back(mk(1, 9'h030, 32'hBBBBBBBB, 3'b011, 32'h0,       1));
      vecs.push_back(mk(1, 9'h030, 32'hCCCCCCCC, F3_BU, 32'h0,        1));
      vecs.push_back(mk(1, 9'h032, 32'hDDDDDDDD, F3_HU, 32'h0,        1));
      vecs.push_back(mk(1, 9'h033, 32'hEEEEEEEE, F3_H,  32'h0,        1));
      vecs.push_back(mk(0, 9'h030, 32'h0,        F3_W,  32'h11223344, 0));
      vecs.push_back(mk(0, 9'h011, 32'h0,        F3_W,  32'h0,        1));
      vecs.push_back(mk(0, 9'h030, 32'h0,        3'b111, 32'h0,       1));
      vecs.push_back(mk(1, 9'h1FC, 32'hCAFEF00D, F3_W,  32'h0,        0));
      vecs.push_back(mk(0, 9'h1FE, 32'h0,        F3_HU, 32'h0000CAFE, 0));
      vecs.push_back(mk(1, 9'h040, 32'h0BADF00D, F3_W,  32'h0,        0));
      vecs.push_back(mk(0, 9'h040, 32'h0,        F3_W,  32'h0BADF00D, 0));

      // the first word load also holds its response under back-pressure
      foreach (vecs[i]) begin
         accept(vecs[i]);
         finish_txn($sformatf("v%0d", i), (i == 1) ? 5 : 0);
      end

      // Reset while a store is still in BUSY: dropped, outputs cleared.
      accept(mk(1, 9'h040, 32'h12345678, F3_W, 32'h0, 0));
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rbusy.outputs", {req_ready, rsp_valid, rsp_err, 29'b0}, 32'b0);
      reset = 1'b0;
      void'(exp_q.pop_front());
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid) seen++;
      end
      chk("rbusy.no_rsp", 32'(seen), 32'd0);
      chk("rbusy.rdata_cleared", rsp_rdata, 32'b0);
      accept(mk(0, 9'h040, 32'h0, F3_W, 32'h0BADF00D, 0));
      finish_txn("rbusy.reload", 0);

      // Reset while a store sits in RESP: it was already committed.
      accept(mk(1, 9'h050, 32'h55667788, F3_W, 32'h0, 0));
      seen = 0;
      while (!rsp_valid && seen < 20) begin
         @(negedge clk);
         seen++;
      end
      chk("rresp.reached", {31'b0, rsp_valid}, 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      void'(exp_q.pop_front());
      @(negedge clk);
      chk("rresp.valid_cleared", {31'b0, rsp_valid}, 32'd0);
      accept(mk(0, 9'h050, 32'h0, F3_W, 32'h55667788, 0));
      finish_txn("rresp.reload", 0);

      // Zero-wait instance: response on the cycle after acceptance.
      z_txn("z.sw", mk(1, 9'h040, 32'h12345678, F3_W, 32'h0, 0));
      z_txn("z.lw", mk(0, 9'h040, 32'h0, F3_W, 32'h12345678, 0));
      z_txn("z.lb", mk(0, 9'h043, 32'h0, F3_B, 32'h00000012, 0));
      z_txn("z.err", mk(0, 9'h042, 32'h0, F3_W, 32'h0, 1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder serving the pipeline's load/store port over a valid/ready request and response handshake. It holds a byte-addressed, little-endian word array. Each access can be byte, half or word wide, selected by funct3, with sign or zero extension on loads. Service latency is a configurable number of wait states, so the stall and hazard logic can be exercised against a non-ideal memory.

Parameters:
DM_ADDRESS, 9, byte-address width; array depth = 2^(DM_ADDRESS-2) words
DATA_W, 32, data width; only 32 is supported
WAIT_CYCLES, 2, extra cycles between request acceptance and response; 0 is legal

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high; clock clk
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_we  in  1  1 = store, 0 = load
req_addr  in  DM_ADDRESS  byte address
req_wdata  in  DATA_W  store data, right-aligned
req_funct3  in  3  access size/sign (RV32I load/store funct3)
rsp_valid  out  1  response present
rsp_ready  in  1  requester accepts response
rsp_rdata  out  DATA_W  load result, extended; 0 for stores and errors
rsp_err  out  1  illegal funct3 or misaligned access

Behaviour:
- Reset values: req_ready=0 during the reset cycle, then 1; rsp_valid=0, rsp_rdata=0, rsp_err=0; FSM=IDLE; wait counter=0.
- Memory contents are not cleared by reset.
- FSM states: IDLE, BUSY, RESP.
  - IDLE: req_ready=1. On req_valid: latch we/addr/wdata/funct3. Go to BUSY if WAIT_CYCLES>0, else to RESP.
  - BUSY: req_ready=0. Counter counts from WAIT_CYCLES-1 down to 0. At 0 go to RESP.
  - RESP: rsp_valid=1 and req_ready=0. Response fields are held stable until rsp_ready=1, then go to IDLE.
  - No request is accepted in the same cycle as a response handshake. Minimum spacing is one IDLE cycle.
- Latency: request accepted at edge N gives rsp_valid=1 from cycle N+1+WAIT_CYCLES.
- Legal funct3 values:
  - 000 LB/SB, 001 LH/SH, 010 LW/SW
  - 100 LBU, 101 LHU (loads only)
  - Any other value, or 100/101 with we=1, is illegal.
- Misalignment: half with addr[0]=1; word with addr[1:0]!=0.
- Error access: rsp_err=1, rsp_rdata=0, memory unchanged.
- Store commit: on the transition into RESP, the selected bytes are written:
  - SB writes lane addr[1:0] from wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} from wdata[15:0].
  - SW writes all four lanes.
  - Other lanes are preserved.
- Load: the word is read at the transition into RESP and the lane is selected by addr[1:0].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
  - The result is registered into rsp_rdata.
- Word index = addr[DM_ADDRESS-1:2]. There is no out-of-range case; the address wraps naturally within the array.
- Reset mid-operation: a pending BUSY or RESP transaction is discarded. A store still in BUSY is not committed; a store already in RESP stays committed. Outputs return to reset values.
- req_valid while not ready is ignored; the requester must hold it. A request change while req_ready=0 has no effect.

Decomposition:
- Shared package dmem_pkg:
  - funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101
  - state enum dmem_state_t {IDLE,BUSY,RESP}
  - request struct dmem_req_t {we, addr, wdata, funct3}
- Sub-module dmem_lane_align (combinational) takes addr[1:0], funct3, we, wdata and rword. It produces the 4-bit byte-enable, the lane-shifted write word, the extended load data and the err flag. The FSM, counter and array stay in the top level.

Test Plan:
- SW 0xDEADBEEF @0x010, then LW @0x010 with WAIT_CYCLES=2 -> rsp_valid 3 cycles after each acceptance; load rdata=0xDEADBEEF, err=0.
- SB 0x80 @0x013, then LB @0x013 -> 0xFFFFFF80; LBU @0x013 -> 0x00000080; LW @0x010 -> 0x80ADBEEF (other lanes preserved).
- SH 0x8001 @0x022, then LH @0x022 -> 0xFFFF8001; LHU -> 0x00008001; LH @0x021 -> err=1, rdata=0.
- SW @0x031 (misaligned) or funct3=011 -> err=1, memory unchanged; a following LW @0x030 returns the previously written value.
- Hold rsp_ready=0 for 5 cycles during a load response -> rsp_valid, rdata and err stable, req_ready=0 throughout; release -> IDLE next cycle.
- Issue SW 0x12345678 @0x040, assert reset in BUSY -> outputs at reset values, rsp_valid never seen; LW @0x040 returns the prior contents. Repeat with WAIT_CYCLES=0 -> response one cycle after acceptance.
